// File: rtl/ptr_noc_pkg.sv
// Shared types and helpers for the ring local interface: hop-count math
// and the RX arbiter grant encoding.
package ptr_noc_pkg;

  localparam int NODE_NUM_DFLT = 8;
  localparam int DEST_W        = $clog2(NODE_NUM_DFLT);

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_RING = 2'd1,
    GNT_LOOP = 2'd2
  } ptr_gnt_e;

  // Forward distance around the ring from self to dest; 0 means self.
  function automatic int ptr_hop_cnt(input int dest, input int self, input int nodeNum);
    return (dest >= self) ? (dest - self) : (dest + nodeNum - self);
  endfunction

endpackage

// File: rtl/ptr_noc_local_if.sv
// Local-port bundle between a ring router and its local node.
// r2l = router-to-local (show-ahead buffer), l2r = local-to-router.
interface PtrNocLocalIf #(
  parameter int DATA_WIDTH = 32,
  parameter int NODE_NUM   = 8
);
  logic                        r2lPktVld;
  logic                        r2lRd;
  logic [DATA_WIDTH-1:0]       r2lDat;
  logic                        l2rFul;
  logic                        l2rWr;
  logic [DATA_WIDTH-1:0]       l2rDat;
  logic [$clog2(NODE_NUM)-1:0] destCnt;

  modport LocalNode (
    input  r2lPktVld, l2rFul, r2lDat,
    output r2lRd, l2rWr, l2rDat, destCnt
  );

  modport Router (
    output r2lPktVld, l2rFul, r2lDat,
    input  r2lRd, l2rWr, l2rDat, destCnt
  );
endinterface

// File: rtl/ptr_rr_arb2.sv
// Two-requester round-robin arbiter (ring vs. loopback). Grants only while
// enabled; after a contended grant the pointer moves to the loser.
module ptr_rr_arb2
  import ptr_noc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       reqRing,
  input  logic       reqLoop,
  output logic [1:0] gnt
);

  logic     rrPtr;
  ptr_gnt_e gntSel;

  always_comb begin
    gntSel = GNT_NONE;
    if (en) begin
      if (reqRing && reqLoop) gntSel = rrPtr ? GNT_LOOP : GNT_RING;
      else if (reqRing)       gntSel = GNT_RING;
      else if (reqLoop)       gntSel = GNT_LOOP;
    end
  end

  assign gnt = gntSel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rrPtr <= 1'b0;
    end else if (en && reqRing && reqLoop) begin
      rrPtr <= (gntSel == GNT_RING);
    end
  end

endmodule

// File: rtl/ptr_local_node_adapter.sv
// Local-node end of the ring: core TX stream -> router l2r buffer with hop
// count, router r2l buffer -> registered core RX, self-addressed loopback.
module ptr_local_node_adapter
  import ptr_noc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NODE_NUM   = 8,
  parameter int NODE_ID    = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  PtrNocLocalIf.LocalNode             bLocalDat,
  input  logic                        iTxVld,
  output logic                        oTxRdy,
  input  logic [$clog2(NODE_NUM)-1:0] iTxDestId,
  input  logic [DATA_WIDTH-1:0]       iTxDat,
  output logic                        oRxVld,
  input  logic                        iRxRdy,
  output logic [DATA_WIDTH-1:0]       oRxDat,
  output logic                        oDestErr,
  output logic [CNT_WIDTH-1:0]        oTxCnt,
  output logic [CNT_WIDTH-1:0]        oRxCnt
);

  localparam int DestW = $clog2(NODE_NUM);

  logic                  txHoldVld;
  logic [DestW-1:0]      txHoldHop;
  logic [DATA_WIDTH-1:0] txHoldDat;
  logic                  rxVld_p1;
  logic [DATA_WIDTH-1:0] rxDat_p1;
  logic                  destErr;
  logic [CNT_WIDTH-1:0]  txCnt;
  logic [CNT_WIDTH-1:0]  rxCnt;

  logic [1:0]            gntCode;
  ptr_gnt_e              rxGnt;
  logic [DestW-1:0]      hopNext;
  logic                  hopIsSelf;
  logic                  destBad;
  logic                  txAccept;
  logic                  txPopRing;
  logic                  txPopLoop;
  logic                  txPop;
  logic                  loopReq;
  logic                  rxSlotFree;

  assign destBad    = (int'(iTxDestId) >= NODE_NUM);
  assign hopNext    = DestW'(ptr_hop_cnt(int'(iTxDestId), NODE_ID, NODE_NUM));
  assign hopIsSelf  = (txHoldHop == '0);
  assign loopReq    = txHoldVld & hopIsSelf;
  assign rxSlotFree = !rxVld_p1 | iRxRdy;

  // Gating the enable with rst keeps r2lRd quiet while reset is held.
  ptr_rr_arb2 uArb (
    .clk     (clk),
    .rst     (rst),
    .en      (rxSlotFree & rst),
    .reqRing (bLocalDat.r2lPktVld),
    .reqLoop (loopReq),
    .gnt     (gntCode)
  );

  assign rxGnt     = ptr_gnt_e'(gntCode);
  assign txPopRing = txHoldVld & !hopIsSelf & !bLocalDat.l2rFul;
  assign txPopLoop = (rxGnt == GNT_LOOP);
  assign txPop     = txPopRing | txPopLoop;
  assign oTxRdy    = !txHoldVld | txPop;
  assign txAccept  = iTxVld & oTxRdy;

  assign bLocalDat.l2rWr   = txPopRing;
  assign bLocalDat.l2rDat  = txHoldDat;
  assign bLocalDat.destCnt = txHoldHop;
  assign bLocalDat.r2lRd   = (rxGnt == GNT_RING);

  // TX hold stage: bad destinations are swallowed and reported next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      txHoldVld <= 1'b0;
      txHoldHop <= '0;
      txHoldDat <= '0;
      destErr   <= 1'b0;
    end else begin
      destErr <= txAccept & destBad;
      if (txAccept && !destBad) begin
        txHoldVld <= 1'b1;
        txHoldHop <= hopNext;
        txHoldDat <= iTxDat;
      end else if (txPop) begin
        txHoldVld <= 1'b0;
      end
    end
  end

  // RX output stage: refill from the granted source, else drain on ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxVld_p1 <= 1'b0;
      rxDat_p1 <= '0;
    end else begin
      unique case (rxGnt)
        GNT_RING: begin
          rxVld_p1 <= 1'b1;
          rxDat_p1 <= bLocalDat.r2lDat;
        end
        GNT_LOOP: begin
          rxVld_p1 <= 1'b1;
          rxDat_p1 <= txHoldDat;
        end
        default: begin
          if (iRxRdy) rxVld_p1 <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      txCnt <= '0;
      rxCnt <= '0;
    end else begin
      if (txPopRing)         txCnt <= txCnt + 1'b1;
      if (rxVld_p1 && iRxRdy) rxCnt <= rxCnt + 1'b1;
    end
  end

  assign oRxVld   = rxVld_p1;
  assign oRxDat   = rxDat_p1;
  assign oDestErr = destErr;
  assign oTxCnt   = txCnt;
  assign oRxCnt   = rxCnt;

endmodule

// File: tb/tb_ptr_local_node_adapter.sv
// Directed bench for ptr_local_node_adapter: an 8-node ring at node 5 and a
// 6-node ring at node 2 (for out-of-range destinations).
module tb_ptr_local_node_adapter;

  logic clk;
  logic rst;

  PtrNocLocalIf #(.DATA_WIDTH(32), .NODE_NUM(8)) ifA ();
  PtrNocLocalIf #(.DATA_WIDTH(32), .NODE_NUM(6)) ifB ();

  logic        aTxVld, aTxRdy, aRxVld, aRxRdy, aDestErr;
  logic [2:0]  aTxDest;
  logic [31:0] aTxDat, aRxDat;
  logic [15:0] aTxCnt, aRxCnt;

  logic        bTxVld, bTxRdy, bRxVld, bRxRdy, bDestErr;
  logic [2:0]  bTxDest;
  logic [31:0] bTxDat, bRxDat;
  logic [15:0] bTxCnt, bRxCnt;

  ptr_local_node_adapter #(.DATA_WIDTH(32), .NODE_NUM(8), .NODE_ID(5), .CNT_WIDTH(16)) dutA (
    .clk(clk), .rst(rst), .bLocalDat(ifA),
    .iTxVld(aTxVld), .oTxRdy(aTxRdy), .iTxDestId(aTxDest), .iTxDat(aTxDat),
    .oRxVld(aRxVld), .iRxRdy(aRxRdy), .oRxDat(aRxDat), .oDestErr(aDestErr),
    .oTxCnt(aTxCnt), .oRxCnt(aRxCnt)
  );

  ptr_local_node_adapter #(.DATA_WIDTH(32), .NODE_NUM(6), .NODE_ID(2), .CNT_WIDTH(16)) dutB (
    .clk(clk), .rst(rst), .bLocalDat(ifB),
    .iTxVld(bTxVld), .oTxRdy(bTxRdy), .iTxDestId(bTxDest), .iTxDat(bTxDat),
    .oRxVld(bRxVld), .iRxRdy(bRxRdy), .oRxDat(bRxDat), .oDestErr(bDestErr),
    .oTxCnt(bTxCnt), .oRxCnt(bRxCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        txVld;
    logic [2:0]  dest;
    logic [31:0] dat;
    logic        ful;
    logic        eTxRdy;
    logic        eWr;
    logic [2:0]  eCnt;
    logic [31:0] eL2rDat;
    logic        eRxVld;
    logic [31:0] eRxDat;
  } vec_t;

  vec_t        tbl[8];
  int          errors = 0;
  int          checks = 0;
  int          ringIdx, loopIdx, expRing, expLoop;
  logic [31:0] expPrev;
  logic        gRing, sawRd, sawAcc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Test 1: dest 2 -> hop 5, dest 6 -> hop 1, back to back.
    tbl[0] = '{1'b1, 3'd2, 32'h11, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0,  1'b0, 32'h0};
    tbl[1] = '{1'b1, 3'd6, 32'h22, 1'b0, 1'b1, 1'b1, 3'd5, 32'h11, 1'b0, 32'h0};
    tbl[2] = '{1'b0, 3'd0, 32'h0,  1'b0, 1'b1, 1'b1, 3'd1, 32'h22, 1'b0, 32'h0};
    tbl[3] = '{1'b0, 3'd0, 32'h0,  1'b0, 1'b1, 1'b0, 3'd0, 32'h0,  1'b0, 32'h0};
    // Test 3: self-addressed 0xA5 loops back, never touches the ring.
    tbl[4] = '{1'b1, 3'd5, 32'hA5, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0,  1'b0, 32'h0};
    tbl[5] = '{1'b0, 3'd0, 32'h0,  1'b0, 1'b1, 1'b0, 3'd0, 32'h0,  1'b0, 32'h0};
    tbl[6] = '{1'b0, 3'd0, 32'h0,  1'b0, 1'b1, 1'b0, 3'd0, 32'h0,  1'b1, 32'hA5};
    tbl[7] = '{1'b0, 3'd0, 32'h0,  1'b0, 1'b1, 1'b0, 3'd0, 32'h0,  1'b0, 32'h0};

    rst = 1'b0;
    aTxVld = 1'b0; aTxDest = '0; aTxDat = '0; aRxRdy = 1'b1;
    bTxVld = 1'b0; bTxDest = '0; bTxDat = '0; bRxRdy = 1'b1;
    ifA.r2lPktVld = 1'b1; ifA.r2lDat = 32'hDEAD; ifA.l2rFul = 1'b0;
    ifB.r2lPktVld = 1'b0; ifB.r2lDat = '0;       ifB.l2rFul = 1'b0;

    #3;
    chk("rst.txRdy",   32'(aTxRdy), 32'd1);
    chk("rst.rxVld",   32'(aRxVld), 32'd0);
    chk("rst.rxDat",   aRxDat, 32'd0);
    chk("rst.l2rWr",   32'(ifA.l2rWr), 32'd0);
    chk("rst.r2lRd",   32'(ifA.r2lRd), 32'd0);
    chk("rst.destErr", 32'(aDestErr), 32'd0);
    chk("rst.l2rDat",  ifA.l2rDat, 32'd0);
    chk("rst.destCnt", 32'(ifA.destCnt), 32'd0);
    chk("rst.txCnt",   32'(aTxCnt), 32'd0);
    chk("rst.rxCnt",   32'(aRxCnt), 32'd0);
    ifA.r2lPktVld = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      aTxVld = tbl[i].txVld; aTxDest = tbl[i].dest; aTxDat = tbl[i].dat;
      ifA.l2rFul = tbl[i].ful;
      settle();
      chk($sformatf("vec%0d.txRdy", i), 32'(aTxRdy), 32'(tbl[i].eTxRdy));
      chk($sformatf("vec%0d.l2rWr", i), 32'(ifA.l2rWr), 32'(tbl[i].eWr));
      if (tbl[i].eWr) begin
        chk($sformatf("vec%0d.destCnt", i), 32'(ifA.destCnt), 32'(tbl[i].eCnt));
        chk($sformatf("vec%0d.l2rDat", i), ifA.l2rDat, tbl[i].eL2rDat);
      end
      chk($sformatf("vec%0d.rxVld", i), 32'(aRxVld), 32'(tbl[i].eRxVld));
      if (tbl[i].eRxVld) chk($sformatf("vec%0d.rxDat", i), aRxDat, tbl[i].eRxDat);
      tick();
    end
    settle();
    chk("tbl.txCnt", 32'(aTxCnt), 32'd2);
    chk("tbl.rxCnt", 32'(aRxCnt), 32'd1);
    tick();

    // Test 2: l2rFul stalls the hold register; release drains in order.
    ifA.l2rFul = 1'b1; aTxVld = 1'b1; aTxDest = 3'd0; aTxDat = 32'h31;
    settle();
    chk("t2.acc.txRdy", 32'(aTxRdy), 32'd1);
    chk("t2.acc.l2rWr", 32'(ifA.l2rWr), 32'd0);
    tick();
    aTxDest = 3'd7; aTxDat = 32'h32;
    for (int i = 0; i < 9; i++) begin
      settle();
      chk("t2.stall.txRdy", 32'(aTxRdy), 32'd0);
      chk("t2.stall.l2rWr", 32'(ifA.l2rWr), 32'd0);
      tick();
    end
    ifA.l2rFul = 1'b0;
    settle();
    chk("t2.p0.l2rWr", 32'(ifA.l2rWr), 32'd1);
    chk("t2.p0.destCnt", 32'(ifA.destCnt), 32'd3);
    chk("t2.p0.l2rDat", ifA.l2rDat, 32'h31);
    chk("t2.p0.txRdy", 32'(aTxRdy), 32'd1);
    tick();
    aTxDest = 3'd4; aTxDat = 32'h33;
    settle();
    chk("t2.p1.l2rWr", 32'(ifA.l2rWr), 32'd1);
    chk("t2.p1.destCnt", 32'(ifA.destCnt), 32'd2);
    chk("t2.p1.l2rDat", ifA.l2rDat, 32'h32);
    tick();
    aTxVld = 1'b0;
    settle();
    chk("t2.p2.l2rWr", 32'(ifA.l2rWr), 32'd1);
    chk("t2.p2.destCnt", 32'(ifA.destCnt), 32'd7);
    chk("t2.p2.l2rDat", ifA.l2rDat, 32'h33);
    tick();
    settle();
    chk("t2.end.l2rWr", 32'(ifA.l2rWr), 32'd0);
    chk("t2.end.txCnt", 32'(aTxCnt), 32'd5);
    tick();

    // Test 4: ring always pending plus a loopback stream -> alternation.
    ringIdx = 0; loopIdx = 0; expRing = 0; expLoop = 0; expPrev = '0;
    ifA.r2lPktVld = 1'b1; aTxVld = 1'b1; aTxDest = 3'd5; aRxRdy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      ifA.r2lDat = 32'h100 + ringIdx;
      aTxDat     = 32'h200 + loopIdx;
      settle();
      gRing = (k == 0) || (k % 2 == 1);
      chk($sformatf("t4.k%0d.r2lRd", k), 32'(ifA.r2lRd), 32'(gRing));
      chk($sformatf("t4.k%0d.l2rWr", k), 32'(ifA.l2rWr), 32'd0);
      if (k > 0) begin
        chk($sformatf("t4.k%0d.rxVld", k), 32'(aRxVld), 32'd1);
        chk($sformatf("t4.k%0d.rxDat", k), aRxDat, expPrev);
      end
      if (gRing) begin
        expPrev = 32'h100 + expRing;
        expRing++;
      end else begin
        expPrev = 32'h200 + expLoop;
        expLoop++;
      end
      sawRd  = ifA.r2lRd;
      sawAcc = aTxVld & aTxRdy;
      tick();
      if (sawRd)  ringIdx++;
      if (sawAcc) loopIdx++;
    end
    ifA.r2lPktVld = 1'b0; aTxVld = 1'b0;
    settle();
    chk("t4.last.rxDat", aRxDat, expPrev);
    tick();
    settle();
    chk("t4.tail.rxDat", aRxDat, 32'h200 + expLoop);
    tick();
    tick();
    tick();
    settle();
    chk("t4.rxVld", 32'(aRxVld), 32'd0);
    chk("t4.rxCnt", 32'(aRxCnt), 32'd12);
    chk("t4.txCnt", 32'(aTxCnt), 32'd5);
    tick();

    // Test 5: 6-node ring, dest 7 is out of range.
    bTxVld = 1'b1; bTxDest = 3'd7; bTxDat = 32'h55;
    settle();
    chk("t5.txRdy", 32'(bTxRdy), 32'd1);
    chk("t5.pre.destErr", 32'(bDestErr), 32'd0);
    tick();
    bTxVld = 1'b0;
    settle();
    chk("t5.destErr", 32'(bDestErr), 32'd1);
    chk("t5.l2rWr", 32'(ifB.l2rWr), 32'd0);
    chk("t5.rxVld", 32'(bRxVld), 32'd0);
    tick();
    settle();
    chk("t5.post.destErr", 32'(bDestErr), 32'd0);
    chk("t5.post.l2rWr", 32'(ifB.l2rWr), 32'd0);
    chk("t5.post.rxVld", 32'(bRxVld), 32'd0);
    chk("t5.post.txCnt", 32'(bTxCnt), 32'd0);
    chk("t5.post.rxCnt", 32'(bRxCnt), 32'd0);
    tick();
    bTxVld = 1'b1; bTxDest = 3'd0; bTxDat = 32'h66;
    tick();
    bTxVld = 1'b0;
    settle();
    chk("t5.ok.l2rWr", 32'(ifB.l2rWr), 32'd1);
    chk("t5.ok.destCnt", 32'(ifB.destCnt), 32'd4);
    chk("t5.ok.l2rDat", ifB.l2rDat, 32'h66);
    tick();
    settle();
    chk("t5.ok.txCnt", 32'(bTxCnt), 32'd1);
    tick();

    // Test 6: RX backpressure holds data, then reset mid-stall.
    aRxRdy = 1'b0; ifA.r2lPktVld = 1'b1; ifA.r2lDat = 32'h77;
    settle();
    chk("t6.first.r2lRd", 32'(ifA.r2lRd), 32'd1);
    tick();
    ifA.r2lDat = 32'h78;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t6.stall.r2lRd", 32'(ifA.r2lRd), 32'd0);
      chk("t6.stall.rxVld", 32'(aRxVld), 32'd1);
      chk("t6.stall.rxDat", aRxDat, 32'h77);
      tick();
    end
    settle();
    rst = 1'b0;
    #1;
    chk("t6.rst.txRdy",   32'(aTxRdy), 32'd1);
    chk("t6.rst.rxVld",   32'(aRxVld), 32'd0);
    chk("t6.rst.rxDat",   aRxDat, 32'd0);
    chk("t6.rst.r2lRd",   32'(ifA.r2lRd), 32'd0);
    chk("t6.rst.l2rWr",   32'(ifA.l2rWr), 32'd0);
    chk("t6.rst.l2rDat",  ifA.l2rDat, 32'd0);
    chk("t6.rst.destCnt", 32'(ifA.destCnt), 32'd0);
    chk("t6.rst.destErr", 32'(aDestErr), 32'd0);
    chk("t6.rst.txCnt",   32'(aTxCnt), 32'd0);
    chk("t6.rst.rxCnt",   32'(aRxCnt), 32'd0);
    chk("t6.rst.bTxCnt",  32'(bTxCnt), 32'd0);
    ifA.r2lPktVld = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
